// File: rtl/rs_pkg.sv
// Package rs_pkg: reservation-station sizing constants, shared vector/index types and small
// helpers. Imported by the RS dispatch marker, RS storage and the issue controller.
package rs_pkg;

  localparam int unsigned RS_DEPTH = 8;  // number of RS entries (power of two)
  localparam int unsigned RS_IDX_W = 3;  // log2(RS_DEPTH)

  typedef logic [RS_DEPTH-1:0] rs_vec_t;
  typedef logic [RS_IDX_W-1:0] rs_idx_t;

  function automatic rs_vec_t rs_onehot(input rs_idx_t idx);
    rs_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Number of set bits, wide enough to hold RS_DEPTH itself.
  function automatic logic [RS_IDX_W:0] rs_popcount(input rs_vec_t v);
    logic [RS_IDX_W:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      cnt = cnt + {{RS_IDX_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rs_rr_picker.sv
// rs_rr_picker: combinational round-robin find-first over the RS candidate vector.
// Ports:
//   cand    in   RS_DEPTH  candidate slots
//   rr_ptr  in   RS_IDX_W  slot with highest priority; search wraps past RS_DEPTH-1 to 0
//   any     out  1         at least one candidate present
//   idx     out  RS_IDX_W  first candidate at or after rr_ptr (rr_ptr when none)
module rs_rr_picker
  import rs_pkg::*;
(
  input  logic [RS_DEPTH-1:0] cand,
  input  logic [RS_IDX_W-1:0] rr_ptr,
  output logic                any,
  output logic [RS_IDX_W-1:0] idx
);

  rs_idx_t slot;

  always_comb begin
    any  = 1'b0;
    idx  = rr_ptr;
    slot = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      // Index arithmetic wraps naturally because RS_DEPTH is a power of two.
      slot = rr_ptr + rs_idx_t'(i);
      if (!any && cand[slot]) begin
        any = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/rs_issue_ctrl.sv
// rs_issue_ctrl: owns the RS busy vector, sets bits on dispatch, picks one ready busy entry per
// cycle round-robin, presents it to the FU over a valid/ready handshake and frees the slot when
// the FU accepts it.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   alloc_vld/idx   dispatch fills slot alloc_idx
//   entry_rdy       per-slot operands-ready flags from RS storage
//   flush           synchronous drop of all entries (beats alloc and fire)
//   issue_vld/idx   registered issue request; issue_rdy is the FU accept
//   rs_busy         registered busy vector; rs_full / rs_free_cnt derived from it
//   alloc_err       registered pulse: alloc to an occupied slot that is not being freed
// Build option: define RS_PERF_CNT_EN to add perf_stall_cnt[15:0], a saturating count of
// cycles with issue_vld & !issue_rdy, cleared only by reset.
module rs_issue_ctrl
  import rs_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_vld,
  input  logic [RS_IDX_W-1:0] alloc_idx,
  input  logic [RS_DEPTH-1:0] entry_rdy,
  input  logic                flush,
  output logic                issue_vld,
  output logic [RS_IDX_W-1:0] issue_idx,
  input  logic                issue_rdy,
  output logic [RS_DEPTH-1:0] rs_busy,
  output logic                rs_full,
  output logic [RS_IDX_W:0]   rs_free_cnt,
  output logic                alloc_err
`ifdef RS_PERF_CNT_EN
  ,
  output logic [15:0]         perf_stall_cnt
`endif
);

  rs_vec_t busy_q, busy_d, cand;
  rs_idx_t idx_q, idx_d, ptr_q, ptr_d, pick_idx;
  logic    vld_q, vld_d, err_q, err_d, fire, load, pick_any;

  rs_rr_picker u_picker (
    .cand   (cand),
    .rr_ptr (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_comb begin
    fire = vld_q & issue_rdy;
    // The slot already on the output is never picked again while it is pending.
    cand = busy_q & entry_rdy & ~(vld_q ? rs_onehot(idx_q) : '0);
    load = ~vld_q | fire;

    busy_d = busy_q;
    if (fire)      busy_d[idx_q]     = 1'b0;
    if (alloc_vld) busy_d[alloc_idx] = 1'b1;  // set wins over a same-cycle free

    err_d = alloc_vld & busy_q[alloc_idx] & ~(fire & (idx_q == alloc_idx));
    vld_d = load ? pick_any : vld_q;
    idx_d = (load & pick_any) ? pick_idx : idx_q;
    ptr_d = fire ? idx_q + 1'b1 : ptr_q;

    if (flush) begin
      busy_d = '0;
      vld_d  = 1'b0;
      ptr_d  = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      ptr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      ptr_q  <= ptr_d;
      err_q  <= err_d;
    end
  end

  assign issue_vld   = vld_q;
  assign issue_idx   = idx_q;
  assign rs_busy     = busy_q;
  assign rs_full     = &busy_q;
  assign rs_free_cnt = rs_popcount(~busy_q);
  assign alloc_err   = err_q;

`ifdef RS_PERF_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (vld_q && !issue_rdy && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rs_issue_ctrl.sv
// Bench for rs_issue_ctrl: directed scenarios plus random traffic. A reference model predicts the
// registered outputs after every edge and queues them; a monitor compares on the falling edge.
module tb_rs_issue_ctrl;
  import rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_vld;
  logic [2:0]  alloc_idx;
  logic [7:0]  entry_rdy;
  logic        flush;
  logic        issue_vld;
  logic [2:0]  issue_idx;
  logic        issue_rdy;
  logic [7:0]  rs_busy;
  logic        rs_full;
  logic [3:0]  rs_free_cnt;
  logic        alloc_err;
`ifdef RS_PERF_CNT_EN
  logic [15:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  rs_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_vld   (alloc_vld),
    .alloc_idx   (alloc_idx),
    .entry_rdy   (entry_rdy),
    .flush       (flush),
    .issue_vld   (issue_vld),
    .issue_idx   (issue_idx),
    .issue_rdy   (issue_rdy),
    .rs_busy     (rs_busy),
    .rs_full     (rs_full),
    .rs_free_cnt (rs_free_cnt),
    .alloc_err   (alloc_err)
`ifdef RS_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    bit [7:0] busy;
    bit       vld;
    int       idx;
    bit       err;
    int       stall;
  } snap_t;

  snap_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: occupancy per slot, pending request, search start slot.
  bit m_busy[8];
  bit m_vld;
  int m_idx;
  int m_ptr;
  bit m_err;
  int m_stall;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_vld = 0; m_idx = 0; m_ptr = 0; m_err = 0; m_stall = 0;
  endtask

  // Apply one clock edge to the model using the inputs that were present at that edge.
  task automatic model_edge();
    snap_t s;
    bit    fired;
    int    sel;
    if (m_vld && !issue_rdy && m_stall < 65535) m_stall++;
    if (flush) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_vld = 0; m_ptr = 0; m_err = 0;
    end else begin
      fired = m_vld && issue_rdy;
      sel   = -1;
      for (int k = 0; k < 8; k++) begin
        int s_i;
        s_i = (m_ptr + k) % 8;
        if (sel < 0 && m_busy[s_i] && entry_rdy[s_i] && !(m_vld && s_i == m_idx)) sel = s_i;
      end
      m_err = alloc_vld && m_busy[alloc_idx] && !(fired && m_idx == int'(alloc_idx));
      if (fired) begin
        m_busy[m_idx] = 1'b0;
        m_ptr = (m_idx + 1) % 8;
      end
      if (alloc_vld) m_busy[alloc_idx] = 1'b1;
      if (!m_vld || fired) begin
        m_vld = (sel >= 0);
        if (sel >= 0) m_idx = sel;
      end
    end
    s.busy = '0;
    for (int i = 0; i < 8; i++) s.busy[i] = m_busy[i];
    s.vld = m_vld; s.idx = m_idx; s.err = m_err; s.stall = m_stall;
    exp_q.push_back(s);
  endtask

  task automatic step(input bit av, input int ai, input bit [7:0] er, input bit fl,
                      input bit ir);
    alloc_vld = av;
    alloc_idx = 3'(ai);
    entry_rdy = er;
    flush     = fl;
    issue_rdy = ir;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // Monitor: whenever a prediction is outstanding, compare the DUT's registered outputs.
  always @(negedge clk) begin
    snap_t s;
    if (exp_q.size() != 0) begin
      s = exp_q.pop_front();
      chk("rs_busy", int'(rs_busy), int'(s.busy));
      chk("issue_vld", int'(issue_vld), int'(s.vld));
      if (s.vld) chk("issue_idx", int'(issue_idx), s.idx);
      chk("rs_free_cnt", int'(rs_free_cnt), 8 - $countones(s.busy));
      chk("rs_full", int'(rs_full), int'(s.busy == 8'hFF));
      chk("alloc_err", int'(alloc_err), int'(s.err));
`ifdef RS_PERF_CNT_EN
      chk("perf_stall_cnt", int'(perf_stall_cnt), s.stall);
`endif
    end
  end

  initial begin
    rst_n = 1'b0; alloc_vld = 0; alloc_idx = 0; entry_rdy = 0; flush = 0; issue_rdy = 0;
    model_reset();
    #12;
    chk("reset_busy", int'(rs_busy), 0);
    chk("reset_vld", int'(issue_vld), 0);
    chk("reset_idx", int'(issue_idx), 0);
    chk("reset_err", int'(alloc_err), 0);
    chk("reset_free", int'(rs_free_cnt), 8);
    chk("reset_full", int'(rs_full), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single alloc, issue two edges later, freed on fire.
    step(1, 3, 8'h08, 0, 1);
    repeat (3) step(0, 0, 8'h08, 0, 1);

    // Full RS drains 0..7 back to back.
    step(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++) step(1, i, 8'h00, 0, 1);
    repeat (10) step(0, 0, 8'hFF, 0, 1);

    // Stalled request on slot 5 stays put while its ready flag drops.
    step(0, 0, 8'h00, 1, 0);
    step(1, 5, 8'h20, 0, 0);
    repeat (2) step(0, 0, 8'h20, 0, 0);
    repeat (4) step(0, 0, 8'h00, 0, 0);
    repeat (2) step(0, 0, 8'h00, 0, 1);

    // Same-cycle free and re-alloc of slot 2; double alloc of slot 4.
    step(0, 0, 8'h00, 1, 0);
    step(1, 2, 8'h04, 0, 0);
    repeat (2) step(0, 0, 8'h04, 0, 0);
    step(1, 2, 8'h04, 0, 1);
    step(1, 4, 8'h00, 0, 0);
    step(1, 4, 8'h00, 0, 0);
    repeat (2) step(0, 0, 8'h00, 0, 1);

    // Flush beats a same-cycle alloc with a request pending.
    step(0, 0, 8'h00, 1, 0);
    for (int i = 2; i < 6; i++) step(1, i, 8'h00, 0, 0);
    step(0, 0, 8'h3C, 0, 0);
    step(0, 0, 8'h3C, 0, 0);
    step(1, 1, 8'h3C, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Ten stalled cycles, then a flush that must not touch the stall counter.
    step(1, 0, 8'h01, 0, 0);
    repeat (2) step(0, 0, 8'h01, 0, 0);
    repeat (10) step(0, 0, 8'h01, 0, 0);
    step(0, 0, 8'h00, 1, 1);
    step(0, 0, 8'h00, 0, 1);

    // Asynchronous reset in the middle of a stalled handshake.
    step(1, 6, 8'h40, 0, 0);
    repeat (3) step(0, 0, 8'h40, 0, 0);
    alloc_vld = 0; entry_rdy = 0; issue_rdy = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", int'(issue_vld), 0);
    chk("async_rst_busy", int'(rs_busy), 0);
    chk("async_rst_free", int'(rs_free_cnt), 8);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic, including allocs into occupied slots and occasional flushes.
    for (int n = 0; n < 600; n++) begin
      bit [7:0] er;
      er = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom | $urandom);
      step(($urandom % 10) < 4, int'($urandom % 8), er, ($urandom % 50) == 0,
           ($urandom % 10) < 6);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
